// File: rtl/video_clip_pkg.sv
// Shared types and widths for the video window clipper.
// Window coordinates are 12 bit; position counters are 13 bit so that
// start+size sums of two 12-bit values never wrap.
package video_clip_pkg;

   localparam int COORD_W = 12;
   localparam int CNT_W   = 13;
   localparam int ACT_W   = 16;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      CLIP_IDLE       = 2'd0,
      CLIP_WAIT_FRAME = 2'd1,
      CLIP_RUN        = 2'd2
   } clip_state_e;

   // One set of window coefficients, as presented on the inputs or as
   // held in the per-frame shadow copy.
   typedef struct packed {
      logic [COORD_W-1:0] top;
      logic [COORD_W-1:0] left;
      logic [COORD_W-1:0] width;
      logic [COORD_W-1:0] height;
   } window_t;

   // True when start <= pos < start+size, with the sum formed at CNT_W bits.
   function automatic logic in_range(input logic [CNT_W-1:0]   pos,
                                     input logic [COORD_W-1:0] start,
                                     input logic [COORD_W-1:0] size);
      logic [CNT_W-1:0] lo;
      logic [CNT_W-1:0] hi;
      lo = {1'b0, start};
      hi = {1'b0, start} + {1'b0, size};
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/clip_pos_counter.sv
// Position tracking for the clipper: in_vs active-edge and in_de falling-edge
// detection, pixel-in-line and line-in-frame counters. The *_idx outputs give
// the position of the pixel on the inputs this cycle; a frame edge coinciding
// with in_de makes that pixel pix 0 / line 0.
module clip_pos_counter
   import video_clip_pkg::*;
#(
   parameter logic VS_POL = 1'b1
) (
   input  logic             pclk,
   input  logic             prst,
   input  logic             in_vs,
   input  logic             in_de,
   output logic             vs_edge,
   output logic             de_fall,
   output logic [CNT_W-1:0] pix_idx,
   output logic [CNT_W-1:0] line_idx
);

   logic             vs_act;
   logic             vs_act_q;
   logic             de_q;
   logic [CNT_W-1:0] pix_cnt;
   logic [CNT_W-1:0] line_cnt;

   assign vs_act = (in_vs == VS_POL);

   // Edge strobes and the effective position of the current pixel.
   always_comb begin
      vs_edge  = vs_act & ~vs_act_q;
      de_fall  = ~in_de & de_q;
      pix_idx  = vs_edge ? '0 : pix_cnt;
      line_idx = vs_edge ? '0 : line_cnt;
   end

   // Previous-cycle sync levels; reset to inactive so a frame already in
   // progress at release is only picked up at its next active edge.
   always_ff @(posedge pclk) begin
      if (prst) begin
         vs_act_q <= 1'b0;
         de_q     <= 1'b0;
      end else begin
         vs_act_q <= vs_act;
         de_q     <= in_de;
      end
   end

   // Pixel counter: counts in_de cycles, cleared at the end of each line.
   always_ff @(posedge pclk) begin
      if (prst) begin
         pix_cnt <= '0;
      end else if (in_de) begin
         pix_cnt <= pix_idx + CNT_ONE;
      end else if (de_fall || vs_edge) begin
         pix_cnt <= '0;
      end
   end

   // Line counter: advances at each line end, cleared at frame start.
   always_ff @(posedge pclk) begin
      if (prst) begin
         line_cnt <= '0;
      end else if (vs_edge) begin
         line_cnt <= '0;
      end else if (de_fall) begin
         line_cnt <= line_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/video_window_clipper.sv
// Video window clipper: passes only the pixels inside a rectangular window
// of the native stream, with one cycle of latency on every output. Window
// coefficients are sampled once per frame at the in_vs active edge.
// There is no back-pressure: in_de qualifies each pixel and out_de qualifies
// each delivered pixel, one per pclk cycle.
module video_window_clipper
   import video_clip_pkg::*;
#(
   parameter int   DSIZE  = 24,
   parameter logic VS_POL = 1'b1,
   parameter logic HS_POL = 1'b1
) (
   input  logic               pclk,
   input  logic               prst,
   input  logic               enable,
   input  logic [COORD_W-1:0] top,
   input  logic [COORD_W-1:0] left,
   input  logic [COORD_W-1:0] width,
   input  logic [COORD_W-1:0] height,
   input  logic               in_vs,
   input  logic               in_hs,
   input  logic               in_de,
   input  logic [DSIZE-1:0]   in_data,
   output logic               out_vs,
   output logic               out_hs,
   output logic               out_de,
   output logic [DSIZE-1:0]   out_data,
   output logic [ACT_W-1:0]   out_hactive,
   output logic [ACT_W-1:0]   out_vactive,
   output logic               cfg_err,
   output logic [1:0]         dbg_state
);

   localparam logic [1:0] IDLE       = CLIP_IDLE;
   localparam logic [1:0] WAIT_FRAME = CLIP_WAIT_FRAME;
   localparam logic [1:0] RUN        = CLIP_RUN;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             enable_q;

   logic             vs_edge;
   logic             de_fall;
   logic [CNT_W-1:0] pix_idx;
   logic [CNT_W-1:0] line_idx;

   window_t          win_in;
   window_t          shadow;
   window_t          win_eff;

   logic             run_en;
   logic             row_hit;
   logic             col_hit;
   logic             row_seen;
   logic             pix_hit;

   // Per-frame delivery bookkeeping used to flag truncated windows.
   logic             row_open;
   logic [CNT_W-1:0] row_pix;
   logic [CNT_W-1:0] lines_done;
   logic             short_seen;
   logic             line_end;
   logic             line_short;
   logic [CNT_W-1:0] lines_total;
   logic             frame_short;
   logic             zero_win;
   logic             err_set;
   logic             enable_rise;

   clip_pos_counter #(
      .VS_POL (VS_POL)
   ) u_pos (
      .pclk     (pclk),
      .prst     (prst),
      .in_vs    (in_vs),
      .in_de    (in_de),
      .vs_edge  (vs_edge),
      .de_fall  (de_fall),
      .pix_idx  (pix_idx),
      .line_idx (line_idx)
   );

   assign dbg_state = state;
   assign win_in    = {top, left, width, height};

   // Window compare; at a frame edge the freshly presented coefficients
   // apply to the pixel on that same cycle.
   always_comb begin
      win_eff  = vs_edge ? win_in : shadow;
      run_en   = enable && (state == RUN);
      col_hit  = in_range(pix_idx, win_eff.left, win_eff.width);
      row_hit  = in_range(line_idx, win_eff.top, win_eff.height);
      row_seen = in_de && run_en && row_hit;
      pix_hit  = row_seen && col_hit;
   end

   // Delivery checks for the frame that ends at this in_vs edge.
   always_comb begin
      line_end    = de_fall && row_open;
      line_short  = line_end && (row_pix < {1'b0, shadow.width});
      lines_total = lines_done + {{(CNT_W-1){1'b0}}, line_end};
      frame_short = vs_edge && run_en &&
                    (short_seen || line_short ||
                     (lines_total < {1'b0, shadow.height}));
      zero_win    = vs_edge && enable && (state != IDLE) &&
                    ((width == '0) || (height == '0));
      err_set     = frame_short || zero_win;
      enable_rise = enable && !enable_q;
   end

   // Next-state logic; dropping enable returns to IDLE from any state.
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:       state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (vs_edge) state_nxt = RUN;
            RUN:        state_nxt = RUN;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   // State register and enable history.
   always_ff @(posedge pclk) begin
      if (prst) begin
         state    <= IDLE;
         enable_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         enable_q <= enable;
      end
   end

   // Shadow coefficients, refreshed at every frame start.
   always_ff @(posedge pclk) begin
      if (prst) begin
         shadow <= '0;
      end else if (vs_edge) begin
         shadow <= win_in;
      end
   end

   // Count delivered lines and pixels-per-line of the running frame.
   always_ff @(posedge pclk) begin
      if (prst) begin
         row_open   <= 1'b0;
         row_pix    <= '0;
         lines_done <= '0;
         short_seen <= 1'b0;
      end else if (vs_edge || !run_en) begin
         row_open   <= row_seen;
         row_pix    <= {{(CNT_W-1){1'b0}}, pix_hit};
         lines_done <= '0;
         short_seen <= 1'b0;
      end else if (de_fall) begin
         row_open   <= 1'b0;
         row_pix    <= '0;
         lines_done <= lines_total;
         short_seen <= short_seen || line_short;
      end else begin
         if (row_seen) row_open <= 1'b1;
         if (pix_hit)  row_pix  <= row_pix + CNT_ONE;
      end
   end

   // Registered outputs: one pclk of latency from every input.
   always_ff @(posedge pclk) begin
      if (prst) begin
         out_vs      <= ~VS_POL;
         out_hs      <= ~HS_POL;
         out_de      <= 1'b0;
         out_data    <= '0;
         out_hactive <= '0;
         out_vactive <= '0;
      end else begin
         out_vs      <= in_vs;
         out_hs      <= in_hs;
         out_de      <= pix_hit;
         out_data    <= pix_hit ? in_data : '0;
         out_hactive <= {{(ACT_W-COORD_W){1'b0}}, shadow.width};
         out_vactive <= {{(ACT_W-COORD_W){1'b0}}, shadow.height};
      end
   end

   // Sticky configuration error, cleared by reset or a fresh enable.
   always_ff @(posedge pclk) begin
      if (prst) begin
         cfg_err <= 1'b0;
      end else if (enable_rise) begin
         cfg_err <= 1'b0;
      end else if (err_set) begin
         cfg_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_video_window_clipper.sv
// Directed bench for video_window_clipper on a reduced 64x40 raster.
// Each driven cycle pushes its expected output word; the word is popped and
// compared one pclk later, after the DUT has registered that input.
module tb_video_window_clipper;

   localparam int   DSIZE  = 24;
   localparam logic VS_POL = 1'b1;
   localparam logic HS_POL = 1'b1;
   localparam int   EW     = DSIZE + 3;
   localparam int   H_ACT  = 64;
   localparam int   H_BL   = 8;
   localparam int   V_ACT  = 40;
   localparam int   V_BL   = 3;

   logic             pclk = 1'b0;
   logic             prst;
   logic             enable;
   logic [11:0]      top, left, width, height;
   logic             in_vs, in_hs, in_de;
   logic [DSIZE-1:0] in_data;
   logic             out_vs, out_hs, out_de;
   logic [DSIZE-1:0] out_data;
   logic [15:0]      out_hactive, out_vactive;
   logic             cfg_err;
   logic [1:0]       dbg_state;

   int               checks = 0;
   int               failures = 0;
   logic [EW-1:0]    exp_q[$];
   int               m_state;
   logic             m_vs_prev;
   int               m_top, m_left, m_width, m_height;
   int               de_total = 0;
   logic             rst_req;
   int               ev_n;
   int               ev_line[4];
   int               ev_pix[4];
   int               ev_kind[4];
   int               ev_val[4];
   int               n_de;

   // clock / reset block
   always #5 pclk = ~pclk;

   video_window_clipper #(
      .DSIZE  (DSIZE),
      .VS_POL (VS_POL),
      .HS_POL (HS_POL)
   ) dut (
      .pclk        (pclk),
      .prst        (prst),
      .enable      (enable),
      .top         (top),
      .left        (left),
      .width       (width),
      .height      (height),
      .in_vs       (in_vs),
      .in_hs       (in_hs),
      .in_de       (in_de),
      .in_data     (in_data),
      .out_vs      (out_vs),
      .out_hs      (out_hs),
      .out_de      (out_de),
      .out_data    (out_data),
      .out_hactive (out_hactive),
      .out_vactive (out_vactive),
      .cfg_err     (cfg_err),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // driver: one pclk of stimulus, expectation push, then scoreboard pop
   task automatic drive_cycle(input logic vs, input logic hs, input logic de,
                              input int x, input int y);
      logic [DSIZE-1:0] d;
      logic [EW-1:0]    exp_w;
      logic [EW-1:0]    obs_w;
      logic             vs_edge;
      logic             hit;
      @(negedge pclk);
      d       = DSIZE'($urandom_range(32'h00FF_FFFF, 0));
      prst    = rst_req;
      in_vs   = vs;
      in_hs   = hs;
      in_de   = de;
      in_data = d;
      vs_edge = vs && !m_vs_prev;
      if (rst_req) begin
         exp_w     = {~VS_POL, ~HS_POL, 1'b0, {DSIZE{1'b0}}};
         m_state   = 0;
         m_vs_prev = 1'b0;
      end else begin
         if (vs_edge) begin
            m_top    = int'(top);
            m_left   = int'(left);
            m_width  = int'(width);
            m_height = int'(height);
         end
         hit = de && enable && (m_state == 2) &&
               (x >= m_left) && (x < m_left + m_width) &&
               (y >= m_top) && (y < m_top + m_height);
         exp_w = {vs, hs, hit, hit ? d : {DSIZE{1'b0}}};
         if (!enable)                      m_state = 0;
         else if (m_state == 0)            m_state = 1;
         else if (m_state == 1 && vs_edge) m_state = 2;
         m_vs_prev = vs;
      end
      exp_q.push_back(exp_w);
      @(posedge pclk);
      #1;
      obs_w = {out_vs, out_hs, out_de, out_data};
      exp_w = exp_q.pop_front();
      checks++;
      assert (obs_w === exp_w) else begin
         failures++;
         $error("FAIL cycle x=%0d y=%0d observed=%0h expected=%0h", x, y, obs_w, exp_w);
      end
      if (out_de === 1'b1) de_total++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic set_win(input int t, input int l, input int w, input int h);
      top    = 12'(t);
      left   = 12'(l);
      width  = 12'(w);
      height = 12'(h);
   endtask

   task automatic add_ev(input int ln, input int px, input int kind, input int val);
      ev_line[ev_n] = ln;
      ev_pix[ev_n]  = px;
      ev_kind[ev_n] = kind;
      ev_val[ev_n]  = val;
      ev_n++;
   endtask

   // One frame: v_bl blank lines (vs high on line 0), then V_ACT lines of
   // H_ACT pixels followed by H_BL blanking with an hs pulse.
   task automatic run_frame(input int v_bl, output int n);
      int start;
      int y;
      logic de_c;
      start = de_total;
      for (int l = 0; l < v_bl + V_ACT; l++) begin
         y = l - v_bl;
         for (int c = 0; c < H_ACT + H_BL; c++) begin
            de_c    = (y >= 0) && (c < H_ACT);
            rst_req = 1'b0;
            if (de_c) begin
               for (int e = 0; e < ev_n; e++) begin
                  if (ev_line[e] == y && ev_pix[e] == c) begin
                     case (ev_kind[e])
                        1: width   = 12'(ev_val[e]);
                        2: enable  = 1'b0;
                        3: enable  = 1'b1;
                        4: rst_req = 1'b1;
                        default: ;
                     endcase
                  end
               end
            end
            drive_cycle(l == 0, (c >= H_ACT + 2) && (c < H_ACT + 5), de_c, c, y);
         end
      end
      rst_req = 1'b0;
      ev_n    = 0;
      n       = de_total - start;
   endtask

   initial begin
      prst      = 1'b1;
      enable    = 1'b0;
      in_vs     = 1'b0;
      in_hs     = 1'b0;
      in_de     = 1'b0;
      in_data   = '0;
      rst_req   = 1'b1;
      m_state   = 0;
      m_vs_prev = 1'b0;
      m_top     = 0;
      m_left    = 0;
      m_width   = 0;
      m_height  = 0;
      ev_n      = 0;
      set_win(5, 10, 32, 20);

      // reset values
      idle(3);
      check("rst_hactive", out_hactive, 0);
      check("rst_vactive", out_vactive, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_state", dbg_state, 0);
      rst_req = 1'b0;

      enable = 1'b1;
      idle(4);
      check("state_wait", dbg_state, 1);

      // F1: basic window
      run_frame(V_BL, n_de);
      check("f1_de_count", n_de, 20 * 32);
      check("f1_hactive", out_hactive, 32);
      check("f1_vactive", out_vactive, 20);
      check("f1_cfg_err", cfg_err, 0);
      check("f1_state_run", dbg_state, 2);

      // F2: width changed mid-window, current frame unaffected
      add_ev(12, 3, 1, 16);
      run_frame(V_BL, n_de);
      check("f2_de_count", n_de, 20 * 32);
      check("f2_hactive", out_hactive, 32);
      check("f2_cfg_err", cfg_err, 0);

      // F3: new width takes effect
      run_frame(V_BL, n_de);
      check("f3_de_count", n_de, 20 * 16);
      check("f3_hactive", out_hactive, 16);
      check("f3_cfg_err", cfg_err, 0);

      // F4: window runs past the line end, truncated to 14 pixels
      set_win(5, 50, 30, 20);
      run_frame(V_BL, n_de);
      check("f4_de_count", n_de, 20 * 14);
      check("f4_hactive", out_hactive, 30);
      check("f4_cfg_err", cfg_err, 0);

      // F5: truncation of F4 reported at this frame's start
      set_win(5, 10, 32, 20);
      run_frame(V_BL, n_de);
      check("f5_de_count", n_de, 20 * 32);
      check("f5_cfg_err", cfg_err, 1);

      // F6: enable dropped at line 10, raised again at line 15
      add_ev(10, 5, 2, 0);
      add_ev(15, 0, 3, 0);
      run_frame(V_BL, n_de);
      check("f6_de_count", n_de, 5 * 32);
      check("f6_cfg_err", cfg_err, 0);
      check("f6_state_wait", dbg_state, 1);

      // F7: output resumes after the frame edge
      run_frame(V_BL, n_de);
      check("f7_de_count", n_de, 20 * 32);
      check("f7_cfg_err", cfg_err, 0);

      // F8: zero width
      set_win(5, 10, 0, 20);
      run_frame(V_BL, n_de);
      check("f8_de_count", n_de, 0);
      check("f8_cfg_err", cfg_err, 1);
      check("f8_hactive", out_hactive, 0);

      // F9: one-cycle reset mid-line at line 12
      set_win(5, 10, 32, 20);
      add_ev(12, 7, 4, 0);
      run_frame(V_BL, n_de);
      check("f9_de_count", n_de, 7 * 32);
      check("f9_cfg_err", cfg_err, 0);
      check("f9_hactive", out_hactive, 0);
      check("f9_vactive", out_vactive, 0);
      check("f9_state_wait", dbg_state, 1);

      // F10: window back after a full wait
      run_frame(V_BL, n_de);
      check("f10_de_count", n_de, 20 * 32);
      check("f10_cfg_err", cfg_err, 0);
      check("f10_hactive", out_hactive, 32);

      // F11: vs edge on the first active pixel counts as pix 0 / line 0
      set_win(0, 0, 8, 4);
      run_frame(0, n_de);
      check("f11_de_count", n_de, 4 * 8);
      check("f11_cfg_err", cfg_err, 0);
      check("f11_hactive", out_hactive, 8);
      check("f11_vactive", out_vactive, 4);

      // F12: origin window on a normal raster; F11 fully delivered
      run_frame(V_BL, n_de);
      check("f12_de_count", n_de, 4 * 8);
      check("f12_cfg_err", cfg_err, 0);

      idle(2);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
